// File: rtl/ray_column_gen.sv
// Per-frame ray descriptor generator: snapshots the camera on frame_switch and streams
// one ray direction per screen column over a valid/ready interface.
//
// state | meaning
// IDLE  | waiting for frame_switch, no frame in flight
// RUN   | issuing columns 0..SCREEN_WIDTH-1 into the pipeline
// DRAIN | all columns issued, waiting for the last beat to be accepted
module ray_column_gen #(
    parameter int SCREEN_WIDTH = 320,
    parameter int CAM_FRAC     = 16
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        frame_switch,
    input  logic [15:0] posX,
    input  logic [15:0] posY,
    input  logic [15:0] dirX,
    input  logic [15:0] dirY,
    input  logic [15:0] planeX,
    input  logic [15:0] planeY,
    output logic        ray_valid,
    input  logic        ray_ready,
    output logic [9:0]  ray_col,
    output logic [15:0] ray_dirX,
    output logic [15:0] ray_dirY,
    output logic [15:0] ray_posX,
    output logic [15:0] ray_posY,
    output logic        ray_last,
    output logic        busy,
    output logic        frame_done,
    output logic        overrun
);

    localparam int              CAM_STEP    = (2 * (1 << CAM_FRAC) + SCREEN_WIDTH / 2) / SCREEN_WIDTH;
    localparam int              CAM_START_I = -(1 << CAM_FRAC);
    localparam logic [23:0]     CAM_START   = 24'(CAM_START_I);
    localparam logic [23:0]     CAM_INC     = 24'(CAM_STEP);
    localparam logic [9:0]      LAST_COL    = 10'(SCREEN_WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t             state;
    logic [15:0]        pos_x_q, pos_y_q, dir_x_q, dir_y_q;
    logic signed [15:0] plane_x_q, plane_y_q;
    logic [9:0]         col;
    logic signed [23:0] cam_acc;

    logic               s1_valid;
    logic               s1_last;
    logic [9:0]         s1_col;
    logic [15:0]        s1_off_x, s1_off_y;

    logic               stall;
    logic               issue;
    logic signed [39:0] prod_x, prod_y;

    // One global stall: the output register can only move when it is empty or accepted.
    assign stall  = ray_valid && !ray_ready;
    assign issue  = (state == RUN) && !stall;
    assign prod_x = plane_x_q * cam_acc;
    assign prod_y = plane_y_q * cam_acc;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state      <= IDLE;
            pos_x_q    <= '0;
            pos_y_q    <= '0;
            dir_x_q    <= '0;
            dir_y_q    <= '0;
            plane_x_q  <= '0;
            plane_y_q  <= '0;
            col        <= '0;
            cam_acc    <= '0;
            s1_valid   <= 1'b0;
            s1_last    <= 1'b0;
            s1_col     <= '0;
            s1_off_x   <= '0;
            s1_off_y   <= '0;
            ray_valid  <= 1'b0;
            ray_col    <= '0;
            ray_dirX   <= '0;
            ray_dirY   <= '0;
            ray_posX   <= '0;
            ray_posY   <= '0;
            ray_last   <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (frame_switch && state != IDLE)
                overrun <= 1'b1;

            case (state)
                IDLE: begin
                    if (frame_switch) begin
                        pos_x_q   <= posX;
                        pos_y_q   <= posY;
                        dir_x_q   <= dirX;
                        dir_y_q   <= dirY;
                        plane_x_q <= planeX;
                        plane_y_q <= planeY;
                        col       <= '0;
                        cam_acc   <= CAM_START;
                        busy      <= 1'b1;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    if (issue) begin
                        col     <= col + 10'd1;
                        cam_acc <= cam_acc + CAM_INC;
                        if (col == LAST_COL)
                            state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (ray_valid && ray_ready && ray_last) begin
                        frame_done <= 1'b1;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            if (!stall) begin
                // Stage 1: plane * cameraX, floor-shifted back to 8.8
                s1_valid <= issue;
                if (issue) begin
                    s1_col   <= col;
                    s1_last  <= (col == LAST_COL);
                    s1_off_x <= 16'(prod_x >>> CAM_FRAC);
                    s1_off_y <= 16'(prod_y >>> CAM_FRAC);
                end
                // Stage 2: add dir with plain 16-bit wrap
                ray_valid <= s1_valid;
                if (s1_valid) begin
                    ray_col  <= s1_col;
                    ray_last <= s1_last;
                    ray_dirX <= dir_x_q + s1_off_x;
                    ray_dirY <= dir_y_q + s1_off_y;
                    ray_posX <= pos_x_q;
                    ray_posY <= pos_y_q;
                end
            end
        end
    end

endmodule
